// File: rtl/hex_scan_driver_pkg.sv
// hex_scan_pkg: shared constants, scan state type and leading-zero mask helper.
package hex_scan_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
  typedef enum logic {BLANK, SHOW} state_t;
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [15:0] hex, input logic [3:0] point);
    logic [NUM_DIGITS-1:0] m;
    m[3] = hex[15:12] == 4'd0 && !point[3];
    m[2] = m[3] && hex[11:8] == 4'd0 && !point[2];
    m[1] = m[2] && hex[7:4] == 4'd0 && !point[1];
    m[0] = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/hex_scan_driver_if.sv
// hex_scan_driver_if: load bus in, MC14495 decoder and anode drive out.
interface hex_scan_driver_if;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  point_in;
  logic [3:0]  le_in;
  logic [3:0]  hex_out;
  logic        point_out;
  logic        le_out;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;
  modport master(output load, hex_in, point_in, le_in,
                 input hex_out, point_out, le_out, an, frame_start, pending);
  modport slave(input load, hex_in, point_in, le_in,
                output hex_out, point_out, le_out, an, frame_start, pending);
endinterface

// File: rtl/hex_scan_driver_scan_timer.sv
// scan_timer: slot counter, digit index, BLANK/SHOW phase, slot wrap and frame pulse.
module scan_timer
  import hex_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] o_idx,
  output state_t     o_state,
  output logic       o_wrap,
  output logic       o_frame_start
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  state_t        r_state;
  logic          r_frame;
  assign o_wrap        = r_cnt == CW'(SCAN_DIV - 1);
  assign o_idx         = r_idx;
  assign o_state       = r_state;
  assign o_frame_start = r_frame;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= BLANK;
      r_frame <= 1'b0;
    end else begin
      r_cnt   <= o_wrap ? '0 : r_cnt + CW'(1);
      r_idx   <= r_idx + 2'(o_wrap);
      r_state <= o_wrap ? BLANK : (r_cnt == CW'(BLANK_CYC - 1)) ? SHOW : r_state;
      r_frame <= o_wrap && r_idx == 2'd3;
    end
endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: double-buffered 4-digit scan source for a shared MC14495 decoder.
// Define HEX_SCAN_LZ_BLANK_EN to auto-blank leading zero digits at commit.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input logic              clk,
  input logic              rst,
  hex_scan_driver_if.slave bus
);
  logic [1:0]            w_idx, w_nidx;
  state_t                w_state;
  logic                  w_wrap, w_frame, w_commit;
  logic [15:0]           r_act_hex, r_pnd_hex, w_src_hex, w_nxt_hex;
  logic [NUM_DIGITS-1:0] r_act_pt, r_pnd_pt, r_act_le, r_pnd_le;
  logic [NUM_DIGITS-1:0] w_src_pt, w_src_le, w_lz, w_nxt_pt, w_nxt_le;
  logic                  r_pend, r_pt, r_le;
  logic [3:0]            r_hex;

  scan_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk(clk), .rst(rst), .o_idx(w_idx), .o_state(w_state),
    .o_wrap(w_wrap), .o_frame_start(w_frame)
  );

  // a load on the commit edge bypasses the pending buffer
  assign w_commit  = w_wrap && w_idx == 2'd3 && (bus.load || r_pend);
  assign w_src_hex = bus.load ? bus.hex_in : r_pnd_hex;
  assign w_src_pt  = bus.load ? bus.point_in : r_pnd_pt;
  assign w_src_le  = bus.load ? bus.le_in : r_pnd_le;
`ifdef HEX_SCAN_LZ_BLANK_EN
  assign w_lz = lz_mask(w_src_hex, w_src_pt);
`else
  assign w_lz = '0;
`endif
  assign w_nxt_hex = w_commit ? w_src_hex : r_act_hex;
  assign w_nxt_pt  = w_commit ? w_src_pt : r_act_pt;
  assign w_nxt_le  = w_commit ? (w_src_le | w_lz) : r_act_le;
  assign w_nidx    = w_idx + 2'd1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_act_hex <= '0;
      r_act_pt  <= '0;
      r_act_le  <= '1;
      r_pnd_hex <= '0;
      r_pnd_pt  <= '0;
      r_pnd_le  <= '1;
      r_pend    <= 1'b0;
      r_hex     <= '0;
      r_pt      <= 1'b0;
      r_le      <= 1'b1;
    end else begin
      r_act_hex <= w_nxt_hex;
      r_act_pt  <= w_nxt_pt;
      r_act_le  <= w_nxt_le;
      if (w_commit) r_pend <= 1'b0;
      else if (bus.load) begin
        r_pnd_hex <= bus.hex_in;
        r_pnd_pt  <= bus.point_in;
        r_pnd_le  <= bus.le_in;
        r_pend    <= 1'b1;
      end
      if (w_wrap) begin
        r_hex <= w_nxt_hex[{w_nidx, 2'b00} +: 4];
        r_pt  <= w_nxt_pt[w_nidx];
        r_le  <= w_nxt_le[w_nidx];
      end
    end

  assign bus.an          = w_state == SHOW ? ~(4'b0001 << w_idx) : AN_OFF;
  assign bus.le_out      = w_state == SHOW ? r_le : 1'b1;
  assign bus.hex_out     = r_hex;
  assign bus.point_out   = r_pt;
  assign bus.frame_start = w_frame;
  assign bus.pending     = r_pend;
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed checks of scan order, commit, bypass, async reset and LZ blanking.
module tb_hex_scan_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         s, n_chk, n_err;
  logic [3:0] e_an;
`ifdef HEX_SCAN_LZ_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  hex_scan_driver_if bus();
  hex_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input int t);
    while (s < t) begin
      @(negedge clk);
      s++;
    end
  endtask

  task automatic ld(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    bus.load = 1'b1;
    bus.hex_in = h;
    bus.point_in = p;
    bus.le_in = l;
    go(s + 1);
    bus.load = 1'b0;
  endtask

  task automatic slot(input string tag, input int t, input logic [3:0] an_e,
                      input logic [3:0] hex_e, input logic pt_e, input logic le_e);
    go(t);
    chk({tag, "_an"}, 16'(bus.an), 16'(an_e));
    chk({tag, "_hex"}, 16'(bus.hex_out), 16'(hex_e));
    chk({tag, "_pt"}, 16'(bus.point_out), 16'(pt_e));
    chk({tag, "_le"}, 16'(bus.le_out), 16'(le_e));
  endtask

  initial begin
    bus.load = 1'b0;
    bus.hex_in = '0;
    bus.point_in = '0;
    bus.le_in = '0;
    #2;
    chk("rst_an", 16'(bus.an), 16'hF);
    chk("rst_le", 16'(bus.le_out), 16'h1);
    chk("rst_hex", 16'(bus.hex_out), 16'h0);
    chk("rst_pt", 16'(bus.point_out), 16'h0);
    chk("rst_fs", 16'(bus.frame_start), 16'h0);
    chk("rst_pend", 16'(bus.pending), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    s = 0;
    for (int k = 0; k < 40; k++) begin
      go(k);
      e_an = (k % 8 < 2) ? 4'hF : ~(4'b0001 << ((k / 8) % 4));
      chk("scan_an", 16'(bus.an), 16'(e_an));
      chk("scan_fs", 16'(bus.frame_start), 16'(k == 32));
      chk("scan_le", 16'(bus.le_out), 16'h1);
    end
    go(40);
    ld(16'h1234, 4'b0100, 4'h0);
    chk("p2_pend_set", 16'(bus.pending), 16'h1);
    go(63);
    chk("p2_pend_hold", 16'(bus.pending), 16'h1);
    go(64);
    chk("p2_pend_clr", 16'(bus.pending), 16'h0);
    chk("p2_fs", 16'(bus.frame_start), 16'h1);
    chk("p2_blank_le", 16'(bus.le_out), 16'h1);
    chk("p2_settled_hex", 16'(bus.hex_out), 16'h4);
    slot("p2_d0", 66, 4'b1110, 4'h4, 1'b0, 1'b0);
    slot("p2_d1", 74, 4'b1101, 4'h3, 1'b0, 1'b0);
    slot("p2_d2", 82, 4'b1011, 4'h2, 1'b1, 1'b0);
    slot("p2_d3", 90, 4'b0111, 4'h1, 1'b0, 1'b0);
    go(100);
    ld(16'hAAAA, 4'h0, 4'h0);
    go(110);
    ld(16'h5A5F, 4'h0, 4'h0);
    slot("p3_old_d3", 122, 4'b0111, 4'h1, 1'b0, 1'b0);
    chk("p3_pend", 16'(bus.pending), 16'h1);
    slot("p3_d0", 130, 4'b1110, 4'hF, 1'b0, 1'b0);
    slot("p3_d1", 138, 4'b1101, 4'h5, 1'b0, 1'b0);
    slot("p3_d2", 146, 4'b1011, 4'hA, 1'b0, 1'b0);
    slot("p3_d3", 154, 4'b0111, 4'h5, 1'b0, 1'b0);
    go(191);
    ld(16'hBEEF, 4'h0, 4'h0);
    chk("p4_pend", 16'(bus.pending), 16'h0);
    chk("p4_fs", 16'(bus.frame_start), 16'h1);
    slot("p4_d0", 194, 4'b1110, 4'hF, 1'b0, 1'b0);
    slot("p4_d1", 202, 4'b1101, 4'hE, 1'b0, 1'b0);
    chk("p4_pend_after", 16'(bus.pending), 16'h0);
    go(204);
    ld(16'hC0DE, 4'hF, 4'h0);
    go(212);
    chk("p5_pend", 16'(bus.pending), 16'h1);
    chk("p5_an_pre", 16'(bus.an), 16'(4'b1011));
    rst = 1'b1;
    #1;
    chk("p5_async_an", 16'(bus.an), 16'hF);
    chk("p5_async_le", 16'(bus.le_out), 16'h1);
    chk("p5_async_pend", 16'(bus.pending), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    s = 0;
    chk("p5_restart_an", 16'(bus.an), 16'hF);
    slot("p5_d0", 2, 4'b1110, 4'h0, 1'b0, 1'b1);
    slot("p5_d1", 10, 4'b1101, 4'h0, 1'b0, 1'b1);
    slot("p5_d2", 18, 4'b1011, 4'h0, 1'b0, 1'b1);
    slot("p5_d3", 26, 4'b0111, 4'h0, 1'b0, 1'b1);
    go(32);
    chk("p5_fs", 16'(bus.frame_start), 16'h1);
    slot("p5_next_d0", 34, 4'b1110, 4'h0, 1'b0, 1'b1);
    chk("p5_pend_lost", 16'(bus.pending), 16'h0);
    go(40);
    ld(16'h0040, 4'h0, 4'h0);
    slot("p6_d0", 66, 4'b1110, 4'h0, 1'b0, 1'b0);
    slot("p6_d1", 74, 4'b1101, 4'h4, 1'b0, 1'b0);
    slot("p6_d2", 82, 4'b1011, 4'h0, 1'b0, LZ);
    slot("p6_d3", 90, 4'b0111, 4'h0, 1'b0, LZ);
    go(100);
    ld(16'h0000, 4'h0, 4'h0);
    slot("p6z_d0", 130, 4'b1110, 4'h0, 1'b0, 1'b0);
    slot("p6z_d1", 138, 4'b1101, 4'h0, 1'b0, LZ);
    slot("p6z_d2", 146, 4'b1011, 4'h0, 1'b0, LZ);
    slot("p6z_d3", 154, 4'b0111, 4'h0, 1'b0, LZ);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
- Time-multiplexed source for the shared MC14495 hex-to-7-segment decoder on the 4-digit board display.
- Takes a 16-bit hex word plus per-digit point and blank masks and scans them one digit at a time.
- Drives the decoder inputs (D3..D0, point, LE) and the active-low digit anodes, inserting a dead-time blank between digits to prevent ghosting.
- New values are double-buffered and committed only at frame boundaries, so the display never shows a torn frame.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot (≥ BLANK_CYC+1).
- BLANK_CYC, 1000, cycles at the start of each slot with all anodes off (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- load  input  1  one-cycle strobe; captures hex_in/point_in/le_in into pending buffer
- hex_in  input  16  digit3=[15:12] … digit0=[3:0]
- point_in  input  4  per-digit decimal point, bit n = digit n
- le_in  input  4  per-digit blank request (1 = blank), passed to decoder LE
- hex_out  output  4  to decoder {D3,D2,D1,D0}
- point_out  output  1  to decoder point
- le_out  output  1  to decoder LE (1 = blank)
- an  output  4  digit anodes, active-low, one-hot-low when lit
- frame_start  output  1  one-cycle pulse when digit 0 slot begins
- pending  output  1  high while a loaded value awaits commit

Behaviour:
- Reset (async, immediate) values:
  - slot counter 0, digit index 0, state BLANK.
  - an=4'b1111, le_out=1, hex_out=0, point_out=0, frame_start=0, pending=0.
  - Active and pending buffers cleared to 0; le buffers set to 4'hF.
- Slot counter:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, digit index increments modulo 4 (3→0).
- States:
  - BLANK while count < BLANK_CYC: an=4'b1111, le_out=1.
  - SHOW otherwise: an[idx]=0, all other anodes 1.
  - BLANK→SHOW when count = BLANK_CYC-1.
  - SHOW→BLANK on slot wrap.
- Registered outputs:
  - hex_out, point_out and le_out update on the same edge as the digit index, i.e. at slot start, during BLANK. Decoder inputs are therefore settled before the anode turns on.
  - In SHOW: le_out = active le[idx].
- Load:
  - On load=1, pending buffer ← inputs and pending=1 (next edge).
  - A later load before commit overwrites the pending buffer (last wins).
- Commit:
  - Happens on the edge where the index wraps 3→0.
  - If pending=1: active ← pending and pending clears.
  - Load coinciding with that commit edge: the input data goes straight to active (bypass), and pending ends 0.
  - Digit 0 of the new frame already reflects the committed data.
- frame_start: high for exactly the first cycle of digit 0 slot, i.e. the cycle after the 3→0 edge. It is not asserted after reset until the first real wrap.
- Reset mid-slot: immediate blank; scanning restarts at digit 0 with count 0. A pending load is lost.
- Latency: a load issued at any time is visible within at most 4·SCAN_DIV+1 cycles.

Optional Feature:
- Macro HEX_SCAN_LZ_BLANK_EN (leading-zero blanking).
- When defined: at each commit, compute a leading-zero mask from digit 3 downward. Digits 3..1 are forced blank (le=1) while they and all higher digits are 0 and their point bit is 0. Digit 0 is never auto-blanked. The forced mask is ORed with le_in.
- Example: hex 16'h0040, points 0 → digits 3,2 blank; digits 1,0 shown.
- When undefined: le comes from le_in only.

Decomposition:
- Package hex_scan_pkg holds:
  - localparam NUM_DIGITS=4.
  - typedef state_t {BLANK, SHOW}.
  - Anode-off constant 4'b1111.
  - Function lz_mask(hex, point) returning 4 bits.
- One natural sub-module: scan_timer (slot counter, digit index, BLANK/SHOW flag, wrap and frame pulse). The parent holds the buffers and the output mux.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
- Reset then run 40 cycles → an sequence per slot: 1111 ×2 then 1110 ×6, then 1111 ×2 / 1101 ×6, then 1011, then 0111. frame_start pulses only at cycle 32 (first cycle of the second frame). le_out=1 throughout (buffers blank).
- load hex_in=16'h1234, point_in=4'b0100, le_in=0 mid-frame → pending=1 until the 3→0 edge. Next frame hex_out = 4,3,2,1 in slots 0..3; point_out=1 only in slot 2.
- Two loads in one frame (16'hAAAA then 16'h5A5F) → next frame shows F,5,A,5. The AAAA value is never displayed.
- Load coinciding with the 3→0 commit edge (16'hBEEF) → digit 0 of the new frame shows F, and pending=0 afterward.
- Assert rst in the SHOW phase of digit 2 → an=1111 and le_out=1 in the same cycle (async). After release, scanning restarts at digit 0 with the pending value discarded.
- With HEX_SCAN_LZ_BLANK_EN, load 16'h0040 → le_out=1 in slots 3 and 2, 0 in slots 1 and 0. Load 16'h0000 → only digit 0 is shown.
